// File: rtl/dxm_cdc_tx_pkg.sv
// Shared definitions for the toggle request/acknowledge data crossing.
// Used by the source-side transmitter and the destination-side receiver.
package dxm_cdc_tx_pkg;

  // Two-phase protocol: a transfer is outstanding while req != ack.
  // The source toggles req once per word. The destination toggles ack once
  // it has captured the data. Both toggles reset to 0 from the shared rst_n.
  typedef enum logic {
    DXM_CDC_IDLE = 1'b0,
    DXM_CDC_WAIT = 1'b1
  } dxm_cdc_state_e;

  localparam int DXM_CDC_SYNC_STAGES_DEF = 2;

  function automatic logic dxm_toggle_match(input logic i_req, input logic i_ack);
    return (i_req == i_ack);
  endfunction

endpackage

// File: rtl/dxm_sync_n.sv
// Multi-stage async-reset synchroniser for a single-bit level or toggle.
// The output resets to 0 and follows the input after STAGES clk edges.
module dxm_sync_n #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q
);

  logic [STAGES-1:0] r_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync <= '0;
    end else begin
      r_sync <= {r_sync[STAGES-2:0], i_d};
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dxm_cdc_tx.sv
// Source-side transmitter of the toggle req/ack crossing.
// Holds one word on tx_data until the resynchronised ack matches tx_req.
module dxm_cdc_tx
  import dxm_cdc_tx_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int SYNC_STAGES = DXM_CDC_SYNC_STAGES_DEF,
  parameter int TO_W        = 8,
  parameter int TO_CYC      = 200
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  output logic              in_ready,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_data,
  input  logic              rx_ack,
  output logic              busy,
  output logic              timeout_err,
  input  logic              err_clr
);

  localparam logic [TO_W-1:0] LP_TO_MAX = TO_W'(TO_CYC);
  localparam logic [TO_W-1:0] LP_TO_PRE = TO_W'(TO_CYC - 1);

  dxm_cdc_state_e    r_state;
  dxm_cdc_state_e    w_state_nxt;
  logic              r_tx_req;
  logic [DATA_W-1:0] r_tx_data;
  logic [TO_W-1:0]   r_cnt;
  logic              r_timeout_err;
  logic              w_ack_s;
  logic              w_ack_match;
  logic              w_accept;
  logic              w_waiting;
  logic              w_to_hit;

  dxm_sync_n #(
    .STAGES (SYNC_STAGES)
  ) u_ack_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (rx_ack),
    .o_q   (w_ack_s)
  );

  assign w_ack_match = dxm_toggle_match(r_tx_req, w_ack_s);

  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_waiting   = 1'b0;
    case (r_state)
      DXM_CDC_IDLE: begin
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = DXM_CDC_WAIT;
        end
      end
      DXM_CDC_WAIT: begin
        if (w_ack_match) begin
          w_state_nxt = DXM_CDC_IDLE;
        end else begin
          w_waiting = 1'b1;
        end
      end
      default: w_state_nxt = DXM_CDC_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= DXM_CDC_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Data and request change only on the accept edge; frozen while waiting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_req  <= 1'b0;
      r_tx_data <= '0;
    end else if (w_accept) begin
      r_tx_req  <= ~r_tx_req;
      r_tx_data <= in_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_accept) begin
      r_cnt <= '0;
    end else if (w_waiting && (r_cnt != LP_TO_MAX)) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Flag on the edge the counter reaches TO_CYC; set beats a coincident clear.
  assign w_to_hit = w_waiting && (r_cnt == LP_TO_PRE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_timeout_err <= 1'b0;
    end else if (w_to_hit) begin
      r_timeout_err <= 1'b1;
    end else if (err_clr) begin
      r_timeout_err <= 1'b0;
    end
  end

  assign in_ready    = (r_state == DXM_CDC_IDLE);
  assign busy        = (r_state == DXM_CDC_WAIT);
  assign tx_req      = r_tx_req;
  assign tx_data     = r_tx_data;
  assign timeout_err = r_timeout_err;

endmodule

// File: tb/tb_dxm_cdc_tx.sv
// Directed bench for dxm_cdc_tx with a hand-driven destination acknowledge.
module tb_dxm_cdc_tx;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic [31:0] in_data;
  logic        in_ready;
  logic        tx_req;
  logic [31:0] tx_data;
  logic        rx_ack;
  logic        busy;
  logic        timeout_err;
  logic        err_clr;

  int n_chk;
  int n_err;
  int n_viol;
  int n_req_edges;
  logic last_ack;
  logic last_req;
  logic exp_req;
  int   lat;
  logic [31:0] words [4];
  logic [31:0] held;

  dxm_cdc_tx #(
    .DATA_W      (32),
    .SYNC_STAGES (2),
    .TO_W        (8),
    .TO_CYC      (200)
  ) u_dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .tx_req      (tx_req),
    .tx_data     (tx_data),
    .rx_ack      (rx_ack),
    .busy        (busy),
    .timeout_err (timeout_err),
    .err_clr     (err_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Protocol monitor: ack toggling with no transfer outstanding is a violation.
  initial begin
    n_viol      = 0;
    n_req_edges = 0;
    last_ack    = 1'b0;
    last_req    = 1'b0;
  end

  always @(posedge clk) begin
    if (rst_n && (rx_ack != last_ack) && !busy) n_viol = n_viol + 1;
    if (rst_n && (tx_req != last_req)) n_req_edges = n_req_edges + 1;
    last_ack = rx_ack;
    last_req = tx_req;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk = n_chk + 1;
    if (got !== exp) begin
      n_err = n_err + 1;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(output int n);
    n = 0;
    while (!in_ready && n < 20) begin
      tick();
      n = n + 1;
    end
    chk("ready_wait", {31'd0, in_ready}, 32'd1);
  endtask

  task automatic do_reset();
    rst_n  = 1'b0;
    rx_ack = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    exp_req = 1'b0;
  endtask

  task automatic send_ack();
    rx_ack = ~rx_ack;
  endtask

  initial begin
    n_chk    = 0;
    n_err    = 0;
    rst_n    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    rx_ack   = 1'b0;
    err_clr  = 1'b0;
    exp_req  = 1'b0;
    words[0] = 32'h1;
    words[1] = 32'h2;
    words[2] = 32'h3;
    words[3] = 32'h4;

    // reset values
    do_reset();
    chk("rst_tx_req", {31'd0, tx_req}, 32'd0);
    chk("rst_tx_data", tx_data, 32'h0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_timeout", {31'd0, timeout_err}, 32'd0);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // single word
    in_valid = 1'b1;
    in_data  = 32'hA5A5_1234;
    tick();
    in_valid = 1'b0;
    exp_req  = ~exp_req;
    chk("single_data", tx_data, 32'hA5A5_1234);
    chk("single_req", {31'd0, tx_req}, {31'd0, exp_req});
    chk("single_busy", {31'd0, busy}, 32'd1);
    chk("single_not_ready", {31'd0, in_ready}, 32'd0);
    repeat (6) tick();
    chk("single_still_busy", {31'd0, busy}, 32'd1);
    send_ack();
    wait_ready(lat);
    chk("single_ack_lat", lat, 32'd3);
    chk("single_timeout", {31'd0, timeout_err}, 32'd0);

    // back-to-back four words, ack three cycles after each request edge
    do_reset();
    n_req_edges = 0;
    in_valid = 1'b1;
    in_data  = words[0];
    for (int i = 0; i < 4; i++) begin
      wait_ready(lat);
      if (i > 0) chk("b2b_ack_lat", lat, 32'd3);
      tick();
      exp_req = ~exp_req;
      chk("b2b_req", {31'd0, tx_req}, {31'd0, exp_req});
      chk("b2b_data", tx_data, words[i]);
      if (i < 3) in_data = words[i+1];
      else in_valid = 1'b0;
      tick();
      chk("b2b_hold1", tx_data, words[i]);
      tick();
      chk("b2b_hold2", tx_data, words[i]);
      held = tx_data;
      chk("b2b_rx_word", held, words[i]);
      send_ack();
    end
    wait_ready(lat);
    chk("b2b_last_lat", lat, 32'd3);
    chk("b2b_req_edges", n_req_edges, 32'd4);

    // stall: in_valid held with changing data while waiting
    in_valid = 1'b1;
    in_data  = 32'hC0DE_0001;
    tick();
    exp_req = ~exp_req;
    chk("stall_req", {31'd0, tx_req}, {31'd0, exp_req});
    for (int i = 1; i <= 6; i++) begin
      in_data = 32'h1111_1111 * i;
      tick();
      chk("stall_data", tx_data, 32'hC0DE_0001);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
    end
    in_valid = 1'b0;
    send_ack();
    wait_ready(lat);
    chk("stall_ack_lat", lat, 32'd3);
    chk("stall_data_after", tx_data, 32'hC0DE_0001);

    // timeout: no ack for 250 cycles
    in_valid = 1'b1;
    in_data  = 32'h7777_0000;
    tick();
    in_valid = 1'b0;
    exp_req  = ~exp_req;
    repeat (199) tick();
    chk("to_before", {31'd0, timeout_err}, 32'd0);
    tick();
    chk("to_set", {31'd0, timeout_err}, 32'd1);
    chk("to_busy", {31'd0, busy}, 32'd1);
    repeat (49) tick();
    chk("to_still_busy", {31'd0, busy}, 32'd1);
    chk("to_sticky", {31'd0, timeout_err}, 32'd1);
    chk("to_req_frozen", {31'd0, tx_req}, {31'd0, exp_req});
    send_ack();
    wait_ready(lat);
    chk("to_ack_lat", lat, 32'd3);
    chk("to_sticky_idle", {31'd0, timeout_err}, 32'd1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    chk("to_clear", {31'd0, timeout_err}, 32'd0);

    // spurious ack toggle while idle
    send_ack();
    repeat (5) tick();
    chk("spur_req", {31'd0, tx_req}, {31'd0, exp_req});
    chk("spur_data", tx_data, 32'h7777_0000);
    chk("spur_ready", {31'd0, in_ready}, 32'd1);
    chk("spur_busy", {31'd0, busy}, 32'd0);
    in_valid = 1'b1;
    in_data  = 32'h5A5A_0000;
    tick();
    in_valid = 1'b0;
    exp_req  = ~exp_req;
    chk("spur_accept_busy", {31'd0, busy}, 32'd1);
    tick();
    chk("spur_fast_done", {31'd0, in_ready}, 32'd1);
    chk("spur_viol_seen", n_viol, 32'd1);

    // asynchronous reset in the middle of a transfer
    in_valid = 1'b1;
    in_data  = 32'h1234_0000;
    tick();
    in_valid = 1'b0;
    tick();
    chk("rmid_busy_pre", {31'd0, busy}, 32'd1);
    rst_n  = 1'b0;
    rx_ack = 1'b0;
    #2;
    chk("rmid_req", {31'd0, tx_req}, 32'd0);
    chk("rmid_data", tx_data, 32'h0);
    chk("rmid_busy", {31'd0, busy}, 32'd0);
    chk("rmid_timeout", {31'd0, timeout_err}, 32'd0);
    tick();
    rst_n   = 1'b1;
    exp_req = 1'b0;
    tick();
    chk("rmid_ready", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = 32'h0BAD_F00D;
    tick();
    in_valid = 1'b0;
    exp_req  = ~exp_req;
    chk("rmid_fresh_req", {31'd0, tx_req}, {31'd0, exp_req});
    chk("rmid_fresh_data", tx_data, 32'h0BAD_F00D);
    tick();
    tick();
    send_ack();
    wait_ready(lat);
    chk("rmid_fresh_lat", lat, 32'd3);
    chk("rmid_viol_total", n_viol, 32'd1);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
